// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_share_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req0_ainv;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              req1_ainv;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic              alu_ainv;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_ovf;
    logic              alu_cout;

    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_ovf;
    logic              rsp_cout;
    logic              rsp_ready;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_ainv,
        input  req1_valid, req1_a, req1_b, req1_op, req1_ainv,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op, alu_ainv,
        input  alu_result, alu_zero, alu_ovf, alu_cout,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_ainv,
        output req1_valid, req1_a, req1_b, req1_op, req1_ainv,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op, alu_ainv,
        output alu_result, alu_zero, alu_ovf, alu_cout,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_cout,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one external combinational ALU16.
// One operation in flight: IDLE accepts, EXEC captures the ALU output, RESP holds it.
module alu_share_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant_c;
    logic              accept_c;
    logic              last_grant;
    logic              owner;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              ainv_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_ovf_q;
    logic              rsp_cout_q;

    // Winner selection; a lone requester wins regardless of history.
    always_comb begin : arbitrate
        grant_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = PRIO_FIXED ? 1'b0 : ~last_grant;
        end else if (bus.req1_valid) begin
            grant_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Readies are gated by reset so nothing is accepted on a reset edge.
    always_comb begin : fsm_next
        state_nxt      = state;
        accept_c       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if ((bus.req0_valid || bus.req1_valid) && !reset) begin
                    accept_c       = 1'b1;
                    bus.req0_ready = ~grant_c;
                    bus.req1_ready = grant_c;
                    state_nxt      = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (reset) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            ainv_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_cout_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                last_grant <= grant_c;
                owner      <= grant_c;
                a_q        <= grant_c ? bus.req1_a    : bus.req0_a;
                b_q        <= grant_c ? bus.req1_b    : bus.req0_b;
                op_q       <= grant_c ? bus.req1_op   : bus.req0_op;
                ainv_q     <= grant_c ? bus.req1_ainv : bus.req0_ainv;
            end
            if (state == EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= owner;
                rsp_result_q <= bus.alu_result;
                rsp_zero_q   <= bus.alu_zero;
                rsp_ovf_q    <= bus.alu_ovf;
                rsp_cout_q   <= bus.alu_cout;
            end else if ((state == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_ainv   = ainv_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_ovf    = rsp_ovf_q;
    assign bus.rsp_cout   = rsp_cout_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each wired to a
// small ALU16 model; expected values are hand-computed constants.
module tb_alu_share_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_share_arbiter_if if0 ();
    alu_share_arbiter_if if1 ();

    alu_share_arbiter #(.PRIO_FIXED(1'b0)) dut_rr  (.clk(clk), .reset(reset), .bus(if0));
    alu_share_arbiter #(.PRIO_FIXED(1'b1)) dut_fix (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU16: Op[3] negates B and supplies carry-in, Op[2:0]=100 is add.
    function automatic logic [18:0] alu16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic ainv);
        logic [15:0] aa, bb, r;
        logic [16:0] s;
        logic        v;
        aa = ainv ? ~a : a;
        bb = op[3] ? ~b : b;
        s  = {1'b0, aa} + {1'b0, bb} + 17'(op[3]);
        case (op[2:0])
            3'b000:  r = aa & bb;
            3'b001:  r = aa | bb;
            3'b100:  r = s[15:0];
            default: r = aa ^ bb;
        endcase
        v = (aa[15] == bb[15]) && (s[15] != aa[15]);
        return {r, (r == 16'h0000), v, s[16]};
    endfunction

    always_comb {if0.alu_result, if0.alu_zero, if0.alu_ovf, if0.alu_cout} =
        alu16(if0.alu_a, if0.alu_b, if0.alu_op, if0.alu_ainv);
    always_comb {if1.alu_result, if1.alu_zero, if1.alu_ovf, if1.alu_cout} =
        alu16(if1.alu_a, if1.alu_b, if1.alu_op, if1.alu_ainv);

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Present one request on if0, wait for accept and response (bounded).
    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic ainv,
                         output int acc_lat, output int rsp_lat);
        if (id) begin
            if0.req1_valid = 1'b1; if0.req1_a = a; if0.req1_b = b;
            if0.req1_op = op; if0.req1_ainv = ainv;
        end else begin
            if0.req0_valid = 1'b1; if0.req0_a = a; if0.req0_b = b;
            if0.req0_op = op; if0.req0_ainv = ainv;
        end
        acc_lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? if0.req1_ready : if0.req0_ready) === 1'b1) begin
                acc_lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (id) if0.req1_valid = 1'b0; else if0.req0_valid = 1'b0;
        rsp_lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.rsp_valid === 1'b1) begin
                rsp_lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if0.req0_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", if0.req0_ready, if0.req1_ready);
        end
        checks++;
        if ({if0.rsp_valid, if0.rsp_id, if0.rsp_result, if0.rsp_zero, if0.rsp_ovf, if0.rsp_cout} !== 21'h0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%b res=%h expected all zero",
                     if0.rsp_valid, if0.rsp_id, if0.rsp_result);
        end
        checks++;
        if ({if0.alu_a, if0.alu_b, if0.alu_op, if0.alu_ainv} !== 37'h0) begin
            errors++;
            $display("FAIL reset_alu_regs: got a=%h b=%h op=%h ainv=%b expected all zero",
                     if0.alu_a, if0.alu_b, if0.alu_op, if0.alu_ainv);
        end
        @(posedge clk); #1;
        if0.req0_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_add();
        int acc, rsp;
        issue(1'b0, 16'd100, 16'd85, 4'b0100, 1'b0, acc, rsp);
        checks++;
        if (acc != 0 || rsp != 1) begin
            errors++;
            $display("FAIL add_latency: got acc=%0d rsp=%0d expected acc=0 rsp=1", acc, rsp);
        end
        checks++;
        if (if0.rsp_id !== 1'b0 || if0.rsp_result !== 16'd185 || if0.rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_result: got id=%b res=%0d z=%b expected id=0 res=185 z=0",
                     if0.rsp_id, if0.rsp_result, if0.rsp_zero);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if0.rsp_valid !== 1'b0 || if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0
            || if0.alu_a !== 16'd100 || if0.alu_b !== 16'd85) begin
            errors++;
            $display("FAIL idle_hold: got v=%b rdy=%b%b a=%0d b=%0d expected v=0 rdy=00 a=100 b=85",
                     if0.rsp_valid, if0.req0_ready, if0.req1_ready, if0.alu_a, if0.alu_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int acc, rsp;
        issue(1'b1, 16'd100, 16'd100, 4'b1100, 1'b0, acc, rsp);
        checks++;
        if (acc != 0 || rsp != 1 || if0.rsp_id !== 1'b1 || if0.rsp_result !== 16'h0000
            || if0.rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: got acc=%0d rsp=%0d id=%b res=%h z=%b expected 0 1 id=1 res=0000 z=1",
                     acc, rsp, if0.rsp_id, if0.rsp_result, if0.rsp_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flags();
        int acc, rsp;
        issue(1'b0, 16'h7FFF, 16'h0001, 4'b0100, 1'b0, acc, rsp);
        checks++;
        if (rsp != 1 || if0.rsp_result !== 16'h8000 || if0.rsp_ovf !== 1'b1 || if0.rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL flags_ovf: got res=%h ovf=%b cout=%b expected res=8000 ovf=1 cout=0",
                     if0.rsp_result, if0.rsp_ovf, if0.rsp_cout);
        end
        @(posedge clk); #1;
        issue(1'b0, 16'hFFFF, 16'h0001, 4'b0100, 1'b0, acc, rsp);
        checks++;
        if (rsp != 1 || if0.rsp_result !== 16'h0000 || if0.rsp_cout !== 1'b1
            || if0.rsp_zero !== 1'b1 || if0.rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL flags_cout: got res=%h cout=%b z=%b ovf=%b expected res=0000 cout=1 z=1 ovf=0",
                     if0.rsp_result, if0.rsp_cout, if0.rsp_zero, if0.rsp_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int acc, rsp;
        if0.rsp_ready = 1'b0;
        issue(1'b0, 16'h1234, 16'h0001, 4'b0100, 1'b0, acc, rsp);
        if0.req1_valid = 1'b1; if0.req1_a = 16'd3; if0.req1_b = 16'd5;
        if0.req1_op = 4'b1100; if0.req1_ainv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (if0.rsp_valid !== 1'b1 || if0.rsp_id !== 1'b0 || if0.rsp_result !== 16'h1235
                || if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b id=%b res=%h rdy=%b%b expected v=1 id=0 res=1235 rdy=00",
                         i, if0.rsp_valid, if0.rsp_id, if0.rsp_result, if0.req0_ready, if0.req1_ready);
            end
        end
        @(posedge clk); #1;
        if0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if0.rsp_valid !== 1'b0 || if0.req1_ready !== 1'b1 || if0.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_accept: got v=%b rdy=%b%b expected v=0 rdy=01",
                     if0.rsp_valid, if0.req0_ready, if0.req1_ready);
        end
        @(posedge clk); #1;
        if0.req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if0.rsp_valid !== 1'b1 || if0.rsp_id !== 1'b1 || if0.rsp_result !== 16'hFFFE || if0.rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL pending_rsp: got v=%b id=%b res=%h cout=%b expected v=1 id=1 res=FFFE cout=0",
                     if0.rsp_valid, if0.rsp_id, if0.rsp_result, if0.rsp_cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec();
        // Accepting req0 leaves the pointer at 0; only a reset makes req0 win the next tie.
        if0.req0_valid = 1'b1; if0.req0_a = 16'd7; if0.req0_b = 16'd9;
        if0.req0_op = 4'b0100; if0.req0_ainv = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        if0.req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({if0.rsp_valid, if0.rsp_id, if0.rsp_result, if0.rsp_zero, if0.rsp_ovf, if0.rsp_cout} !== 21'h0
            || {if0.alu_a, if0.alu_b, if0.alu_op, if0.alu_ainv} !== 37'h0) begin
            errors++;
            $display("FAIL reset_exec: got v=%b id=%b res=%h a=%h ainv=%b expected all zero",
                     if0.rsp_valid, if0.rsp_id, if0.rsp_result, if0.alu_a, if0.alu_ainv);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if0.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec_norsp: got v=%b expected v=0", if0.rsp_valid);
        end
        @(posedge clk); #1;
        if0.req0_valid = 1'b1;
        if0.req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.req0_ready !== 1'b1 || if0.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got rdy=%b%b expected rdy=10", if0.req0_ready, if0.req1_ready);
        end
        @(posedge clk); #1;
        if0.req0_valid = 1'b0;
        if0.req1_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int n, last_cyc;
        do_reset();
        if0.req0_valid = 1'b1; if0.req1_valid = 1'b1;
        n = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 14 && n < 4; cyc++) begin
            @(negedge clk);
            if (if0.req0_ready === 1'b1 || if0.req1_ready === 1'b1) begin
                checks++;
                if (if0.req1_ready !== n[0] || if0.req0_ready !== ~n[0]
                    || (last_cyc >= 0 && cyc - last_cyc != 3)) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: got rdy=%b%b gap=%0d expected winner=%0d gap=3",
                             n, if0.req0_ready, if0.req1_ready, cyc - last_cyc, n % 2);
                end
                last_cyc = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d grants expected 4", n);
        end
        if0.req0_valid = 1'b0; if0.req1_valid = 1'b0;
    endtask

    task automatic test_fixed_priority();
        int n, last_cyc;
        do_reset();
        if1.req0_valid = 1'b1; if1.req1_valid = 1'b1;
        n = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 14 && n < 4; cyc++) begin
            @(negedge clk);
            if (if1.req0_ready === 1'b1 || if1.req1_ready === 1'b1) begin
                checks++;
                if (if1.req0_ready !== 1'b1 || if1.req1_ready !== 1'b0
                    || (last_cyc >= 0 && cyc - last_cyc != 3)) begin
                    errors++;
                    $display("FAIL fixed_grant_%0d: got rdy=%b%b gap=%0d expected rdy=10 gap=3",
                             n, if1.req0_ready, if1.req1_ready, cyc - last_cyc);
                end
                last_cyc = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL fixed_count: got %0d grants expected 4", n);
        end
        if1.req0_valid = 1'b0; if1.req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        if0.req0_valid = 1'b0; if0.req0_a = '0; if0.req0_b = '0; if0.req0_op = '0; if0.req0_ainv = 1'b0;
        if0.req1_valid = 1'b0; if0.req1_a = '0; if0.req1_b = '0; if0.req1_op = '0; if0.req1_ainv = 1'b0;
        if0.rsp_ready  = 1'b1;
        if1.req0_valid = 1'b0; if1.req0_a = 16'd1; if1.req0_b = 16'd2; if1.req0_op = 4'b0100; if1.req0_ainv = 1'b0;
        if1.req1_valid = 1'b0; if1.req1_a = 16'd3; if1.req1_b = 16'd4; if1.req1_op = 4'b0100; if1.req1_ainv = 1'b0;
        if1.rsp_ready  = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_flags();
        test_backpressure();
        test_reset_mid_exec();
        test_round_robin();
        test_fixed_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
